vga_zoom_layers: RTL and testbench



---
 rtl/vga_fx_pkg.sv | 21 ++
 rtl/vga_layer_hit.sv | 37 +++
 rtl/vga_zoom_layers.sv | 104 ++++++++++
 tb/tb_vga_zoom_layers.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/vga_fx_pkg.sv
// Shared types and constants for the TinyVGA effect blocks.
package vga_fx_pkg;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } rgb222_t;

  localparam int H_CENTER = 320;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  // Zoom factor of layer i; layer 0 is the largest copy.
  function automatic logic [7:0] layer_scale(input int step, input int layer);
    int d;
    d = 255 - step * layer;
    return d[7:0];
  endfunction

endpackage

// File: rtl/vga_layer_hit.sv
// Combinational hit test for one scaled copy of the stripe pattern.
module vga_layer_hit
  import vga_fx_pkg::*;
#(
  parameter int LAYER       = 0,
  parameter int LAYER_STEP  = 2,
  parameter int SCALE_SHIFT = 6,
  parameter int CX          = H_CENTER,
  parameter int FRAME_W     = 10
) (
  input  logic [9:0]         hpos,
  input  logic [9:0]         vpos,
  input  logic [FRAME_W-1:0] frame,
  output logic               hit
);

  localparam logic [7:0]        D    = layer_scale(LAYER_STEP, LAYER);
  localparam logic [8:0]        MASK = 9'((LAYER * 8) % 512);
  localparam logic signed [10:0] CX_S = 11'(CX);

  logic signed [10:0] hrel;
  logic signed [19:0] xprod;
  logic [17:0]        yprod;
  logic [7:0]         xs;
  logic [8:0]         ys;

  assign hrel  = $signed({1'b0, hpos}) - CX_S;
  assign xprod = hrel * $signed({1'b0, D});
  assign yprod = vpos * D;

  // Only the low bits of xs/ys are tested, so the wider sums are truncated early.
  assign xs = 8'(xprod >>> SCALE_SHIFT) + 8'(frame);
  assign ys = 9'(yprod >> SCALE_SHIFT);

  assign hit = ((ys & MASK) == 9'd0) && (xs[7:5] == 3'b000);

endmodule

// File: rtl/vga_zoom_layers.sv
// Zoom-layer pattern generator: per-layer hit tests, priority select, 2-stage pipeline.
// Optional colour cycling enabled by defining VGA_PALETTE_CYCLE_EN.
module vga_zoom_layers
  import vga_fx_pkg::*;
#(
  parameter int NUM_LAYERS  = 32,
  parameter int LAYER_STEP  = 2,
  parameter int SCALE_SHIFT = 6,
  parameter int CX          = 320,
  parameter int FRAME_W     = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [9:0]         hpos,
  input  logic [9:0]         vpos,
  input  logic               display_on,
  input  logic               vsync,
  input  logic [1:0]         speed,
  input  logic               dir,
  input  logic               freeze,
  output logic [5:0]         rgb,
  output logic               pix_valid,
  output logic [FRAME_W-1:0] frame
);

  localparam int IDX_W = $clog2(NUM_LAYERS);

  logic                  vsync_q;
  logic [FRAME_W-1:0]    frame_reg;
  logic [FRAME_W-1:0]    step;
  logic [NUM_LAYERS-1:0] hit_comb;
  logic [NUM_LAYERS-1:0] hit_reg;
  logic                  valid_reg;
  logic [IDX_W-1:0]      idx;
  rgb222_t               col;
  rgb222_t               rgb_reg;
  logic                  pix_valid_reg;

  assign step = FRAME_W'(1) << speed;

  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q   <= 1'b1;
      frame_reg <= '0;
    end else begin
      vsync_q <= vsync;
      if (vsync && !vsync_q && !freeze) begin
        frame_reg <= dir ? (frame_reg - step) : (frame_reg + step);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_layer
      vga_layer_hit #(
        .LAYER      (gi),
        .LAYER_STEP (LAYER_STEP),
        .SCALE_SHIFT(SCALE_SHIFT),
        .CX         (CX),
        .FRAME_W    (FRAME_W)
      ) u_hit (
        .hpos (hpos),
        .vpos (vpos),
        .frame(frame_reg),
        .hit  (hit_comb[gi])
      );
    end
  endgenerate

  // Later iterations overwrite earlier ones, so the highest hit layer wins.
  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (hit_reg[i]) idx = IDX_W'(i);
    end
  end

  always_comb begin
`ifdef VGA_PALETTE_CYCLE_EN
    col = (idx == '0) ? rgb222_t'(6'd0) : rgb222_t'(6'(6'(idx) + frame_reg[5:0]));
`else
    col = rgb222_t'(6'(idx));
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_reg       <= '0;
      valid_reg     <= 1'b0;
      rgb_reg       <= '0;
      pix_valid_reg <= 1'b0;
    end else begin
      hit_reg       <= hit_comb;
      valid_reg     <= display_on;
      rgb_reg       <= valid_reg ? col : rgb222_t'(6'd0);
      pix_valid_reg <= valid_reg;
    end
  end

  assign rgb       = rgb_reg;
  assign pix_valid = pix_valid_reg;
  assign frame     = frame_reg;

endmodule

// File: tb/tb_vga_zoom_layers.sv
// Directed + randomized bench for vga_zoom_layers against an arithmetic reference model.
module tb_vga_zoom_layers;

  localparam int NL = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] hpos, vpos;
  logic       display_on, vsync, dir, freeze;
  logic [1:0] speed;
  logic [5:0] rgb;
  logic       pix_valid;
  logic [9:0] frame;

  int checks = 0;
  int errors = 0;
  int exp_frame = 0;

  vga_zoom_layers dut (
    .clk       (clk),
    .reset     (reset),
    .hpos      (hpos),
    .vpos      (vpos),
    .display_on(display_on),
    .vsync     (vsync),
    .speed     (speed),
    .dir       (dir),
    .freeze    (freeze),
    .rgb       (rgb),
    .pix_valid (pix_valid),
    .frame     (frame)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int floor_div64(input int p);
    int q;
    q = p / 64;
    if ((p % 64 != 0) && (p < 0)) q = q - 1;
    return q;
  endfunction

  // Expected {pix_valid, rgb} for one pixel, straight from the layer rules.
  function automatic int model_pix(input int h, input int v, input int f, input bit disp);
    int idx, d, xs, ys, mask, col;
    if (!disp) return 0;
    idx = 0;
    for (int i = 0; i < NL; i++) begin
      d    = 255 - 2 * i;
      xs   = (floor_div64((h - 320) * d) + f) % 32768;
      if (xs < 0) xs += 32768;
      ys   = (v * d) / 64;
      mask = (i * 8) % 512;
      if ((((ys % 512) & mask) == 0) && ((xs % 256) < 32)) idx = i;
    end
`ifdef VGA_PALETTE_CYCLE_EN
    col = (idx == 0) ? 0 : (idx + f) % 64;
`else
    col = idx % 64;
`endif
    return 64 + col;
  endfunction

  function automatic int model_frame(input int f, input int spd, input bit dn, input bit frz);
    int s;
    if (frz) return f;
    s = 1 << spd;
    return (((dn ? f - s : f + s) % 1024) + 1024) % 1024;
  endfunction

  // One vsync rise, held high an extra cycle so a held level is also exercised.
  task automatic vsync_rise(input string tag);
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    tick();
    tick();
    vsync = 1'b0;
    exp_frame = model_frame(exp_frame, speed, dir, freeze);
    chk(tag, frame, exp_frame);
  endtask

  initial begin
    int q[$];
    int e, f0;
    bit d;

    reset = 1'b1; vsync = 1'b1; hpos = '0; vpos = '0; display_on = 1'b0;
    speed = 2'd0; dir = 1'b0; freeze = 1'b0;
    repeat (3) tick();
    chk("reset_rgb", rgb, 0);
    chk("reset_valid", pix_valid, 0);
    chk("reset_frame", frame, 0);
    reset = 1'b0;
    repeat (3) tick();
    chk("release_vsync_high", frame, 0);

    speed = 2'd2; dir = 1'b0;
    vsync_rise("up_4");
    vsync_rise("up_8");
    vsync_rise("up_12");
    chk("frame_12", frame, 12);
    dir = 1'b1;
    vsync_rise("down_8");
    freeze = 1'b1;
    vsync_rise("freeze_a");
    vsync_rise("freeze_b");
    chk("frame_8", frame, 8);
    freeze = 1'b0; speed = 2'd3;
    vsync_rise("down_0");
    speed = 2'd0;
    vsync_rise("wrap_1023");
    chk("frame_1023", frame, 1023);
    dir = 1'b0;
    vsync_rise("wrap_0");

    // Latency: single active pixel at the centre.
    hpos = 10'd320; vpos = 10'd0; display_on = 1'b1;
    tick();
    display_on = 1'b0;
    chk("lat_n1_valid", pix_valid, 0);
    chk("lat_n1_rgb", rgb, 0);
    tick();
    chk("lat_n2_valid", pix_valid, 1);
    chk("lat_n2_rgb", rgb, model_pix(320, 0, exp_frame, 1'b1) % 64);
    chk("lat_n2_rgb31", rgb, 31);
    tick();
    chk("lat_n3_valid", pix_valid, 0);
    chk("lat_n3_rgb", rgb, 0);

    // Blanking: same pixel, display off.
    repeat (2) tick();
    tick();
    chk("blank_valid", pix_valid, 0);
    chk("blank_rgb", rgb, 0);

    // Randomized frame then random pixel stream.
    for (int k = 0; k < 4; k++) begin
      speed = 2'($urandom_range(0, 3));
      dir   = 1'($urandom_range(0, 1));
      vsync_rise("rand_frame");
    end
    for (int c = 0; c < 300; c++) begin
      if ($urandom_range(0, 1) == 1) begin
        hpos = 10'($urandom_range(280, 360));
        vpos = 10'($urandom_range(0, 40));
      end else begin
        hpos = 10'($urandom_range(0, 799));
        vpos = 10'($urandom_range(0, 524));
      end
      d = ($urandom_range(0, 3) != 0);
      display_on = d;
      q.push_back(model_pix(hpos, vpos, exp_frame, d));
      tick();
      if (q.size() >= 2) begin
        e = q.pop_front();
        chk("stream_pix", {pix_valid, rgb}, e);
      end
    end

    // Mid-stream reset with continuous active centre pixels.
    speed = 2'd1; dir = 1'b0;
    vsync_rise("pre_reset_frame");
    hpos = 10'd320; vpos = 10'd0; display_on = 1'b1;
    repeat (3) tick();
    f0 = exp_frame;
    chk("pre_reset_pix", {pix_valid, rgb}, model_pix(320, 0, f0, 1'b1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_frame = 0;
    chk("mid_reset_rgb", rgb, 0);
    chk("mid_reset_valid", pix_valid, 0);
    chk("mid_reset_frame", frame, 0);
    tick();
    chk("post_reset_1_valid", pix_valid, 0);
    tick();
    chk("post_reset_2_pix", {pix_valid, rgb}, model_pix(320, 0, 0, 1'b1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
